// File: rtl/mips_exec_unit_pkg.sv
// Shared types for the MIPS execute stage: ALU operation encoding plus the
// opcode and funct values the ALU control decodes.
package mips_exec_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_NOR   = 5'd5,
    ALU_SLT   = 5'd6,
    ALU_SLTU  = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_SLLV  = 5'd11,
    ALU_SRLV  = 5'd12,
    ALU_SRAV  = 5'd13,
    ALU_LUI   = 5'd14,
    ALU_MULT  = 5'd15,
    ALU_MULTU = 5'd16,
    ALU_DIV   = 5'd17,
    ALU_DIVU  = 5'd18
  } alu_ctrl_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

endpackage

// File: rtl/mips_exec_unit_if.sv
// Operand, control and result bundle between the MIPS control/datapath
// (master) and the execute stage (slave).
interface mips_exec_unit_if;
    logic        clk_enable;
    logic [1:0]  alu_op;
    logic [5:0]  opcode;
    logic [5:0]  function_code;
    logic [4:0]  shamt;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic [31:0] read_data_a;
    logic [31:0] pc_plus4;
    logic        condition_met;
    logic        jump1;
    logic        jump2;

    logic [4:0]  alu_ctrl_in;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] tgt_addr_0;
    logic [31:0] tgt_addr_1;

    modport master (
        output clk_enable, alu_op, opcode, function_code, shamt, A, B,
               branch_addr, jump_addr, read_data_a, pc_plus4,
               condition_met, jump1, jump2,
        input  alu_ctrl_in, alu_out, zero, hi, lo, tgt_addr_0, tgt_addr_1
    );

    modport slave (
        input  clk_enable, alu_op, opcode, function_code, shamt, A, B,
               branch_addr, jump_addr, read_data_a, pc_plus4,
               condition_met, jump1, jump2,
        output alu_ctrl_in, alu_out, zero, hi, lo, tgt_addr_0, tgt_addr_1
    );
endinterface

// File: rtl/mips_exec_unit_alu_core.sv
// Combinational 32-bit ALU with multiply and divide; hi/lo carry the
// mult/div results and are zero for every other operation.
module exec_alu_core
    import mips_exec_pkg::*;
(
    input  alu_ctrl_t   ctrl_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic               div_by_zero, div_ovf;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'b0, a_i} * {32'b0, b_i};

    // Quotients are only selected when the divisor is non-zero and not the
    // 0x80000000 / -1 case, which is patched to its wrapped result below.
    assign div_by_zero = (b_i == 32'b0);
    assign div_ovf     = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign quot_s      = $signed(a_i) / $signed(b_i);
    assign rem_s       = $signed(a_i) % $signed(b_i);
    assign quot_u      = a_i / b_i;
    assign rem_u       = a_i % b_i;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result_o = '0;
        hi_o     = '0;
        lo_o     = '0;
        case (ctrl_i)
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_NOR:   result_o = ~(a_i | b_i);
            ALU_SLT:   result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:  result_o = {31'b0, a_i < b_i};
            ALU_SLL:   result_o = b_i << shamt_i;
            ALU_SRL:   result_o = b_i >> shamt_i;
            ALU_SRA:   result_o = $signed(b_i) >>> shamt_i;
            ALU_SLLV:  result_o = b_i << a_i[4:0];
            ALU_SRLV:  result_o = b_i >> a_i[4:0];
            ALU_SRAV:  result_o = $signed(b_i) >>> a_i[4:0];
            ALU_LUI:   result_o = {b_i[15:0], 16'h0000};
            ALU_MULT:  {hi_o, lo_o} = prod_s;
            ALU_MULTU: {hi_o, lo_o} = prod_u;
            ALU_DIV: begin
                if (div_ovf) begin
                    lo_o = 32'h8000_0000;
                end else if (!div_by_zero) begin
                    lo_o = quot_s;
                    hi_o = rem_s;
                end
            end
            ALU_DIVU: begin
                if (!div_by_zero) begin
                    lo_o = quot_u;
                    hi_o = rem_u;
                end
            end
            default: result_o = a_i + b_i;
        endcase
    end
endmodule

// File: rtl/mips_exec_unit.sv
// MIPS execute stage: ALU control decode, ALU/mult/div core, next-PC target
// select and the target register that holds it across the delay slot.
module mips_exec_unit
    import mips_exec_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mips_exec_unit_if.slave  exec_if
);
    alu_ctrl_t   alu_ctrl;
    logic [31:0] alu_result;
    logic [31:0] tgt_sel;
    logic [31:0] tgt_d, tgt_q;

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (exec_if.alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (exec_if.function_code)
                    FN_SLL:   alu_ctrl = ALU_SLL;
                    FN_SRL:   alu_ctrl = ALU_SRL;
                    FN_SRA:   alu_ctrl = ALU_SRA;
                    FN_SLLV:  alu_ctrl = ALU_SLLV;
                    FN_SRLV:  alu_ctrl = ALU_SRLV;
                    FN_SRAV:  alu_ctrl = ALU_SRAV;
                    FN_MULT:  alu_ctrl = ALU_MULT;
                    FN_MULTU: alu_ctrl = ALU_MULTU;
                    FN_DIV:   alu_ctrl = ALU_DIV;
                    FN_DIVU:  alu_ctrl = ALU_DIVU;
                    FN_SUB:   alu_ctrl = ALU_SUB;
                    FN_AND:   alu_ctrl = ALU_AND;
                    FN_OR:    alu_ctrl = ALU_OR;
                    FN_XOR:   alu_ctrl = ALU_XOR;
                    FN_NOR:   alu_ctrl = ALU_NOR;
                    FN_SLT:   alu_ctrl = ALU_SLT;
                    FN_SLTU:  alu_ctrl = ALU_SLTU;
                    // JR/JALR pass rs through the adder; MTHI/MTLO likewise.
                    FN_ADD, FN_JR, FN_JALR, FN_MTHI, FN_MTLO: alu_ctrl = ALU_ADD;
                    default:  alu_ctrl = ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: begin
                case (exec_if.opcode)
                    OP_ADDIU: alu_ctrl = ALU_ADD;
                    OP_SLTI:  alu_ctrl = ALU_SLT;
                    OP_SLTIU: alu_ctrl = ALU_SLTU;
                    OP_ANDI:  alu_ctrl = ALU_AND;
                    OP_ORI:   alu_ctrl = ALU_OR;
                    OP_XORI:  alu_ctrl = ALU_XOR;
                    OP_LUI:   alu_ctrl = ALU_LUI;
                    default:  alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    exec_alu_core u_alu_core (
        .ctrl_i   (alu_ctrl),
        .a_i      (exec_if.A),
        .b_i      (exec_if.B),
        .shamt_i  (exec_if.shamt),
        .result_o (alu_result),
        .hi_o     (exec_if.hi),
        .lo_o     (exec_if.lo)
    );

    always_comb begin
        tgt_sel = exec_if.pc_plus4;
        if (exec_if.jump2)              tgt_sel = exec_if.read_data_a;
        else if (exec_if.jump1)         tgt_sel = exec_if.jump_addr;
        else if (exec_if.condition_met) tgt_sel = exec_if.branch_addr;
    end

    assign tgt_d = exec_if.clk_enable ? tgt_sel : tgt_q;

    // NOTE: state is updated with non-blocking assignments; reset is asynchronous and wins over the enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tgt_q <= '0;
        else       tgt_q <= tgt_d;
    end

    assign exec_if.alu_ctrl_in = alu_ctrl;
    assign exec_if.alu_out     = alu_result;
    assign exec_if.zero        = (alu_result == 32'b0);
    assign exec_if.tgt_addr_0  = tgt_sel;
    assign exec_if.tgt_addr_1  = tgt_q;
endmodule

// File: tb/tb_mips_exec_unit.sv
// Randomized self-checking bench for mips_exec_unit against a behavioural
// model using 64-bit integer arithmetic.
module tb_mips_exec_unit;

    localparam int C_ADD = 0,  C_SUB = 1,  C_AND = 2,  C_OR = 3,  C_XOR = 4;
    localparam int C_NOR = 5,  C_SLT = 6,  C_SLTU = 7, C_SLL = 8, C_SRL = 9;
    localparam int C_SRA = 10, C_SLLV = 11, C_SRLV = 12, C_SRAV = 13, C_LUI = 14;
    localparam int C_MULT = 15, C_MULTU = 16, C_DIV = 17, C_DIVU = 18;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [31:0] exp_tgt1;

    mips_exec_unit_if exec_if ();

    mips_exec_unit dut (
        .clk     (clk),
        .reset   (reset),
        .exec_if (exec_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int decode(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn);
        int c;
        c = C_ADD;
        if (op == 2'b01) c = C_SUB;
        else if (op == 2'b10) begin
            case (fn)
                6'h00: c = C_SLL;   6'h02: c = C_SRL;   6'h03: c = C_SRA;
                6'h04: c = C_SLLV;  6'h06: c = C_SRLV;  6'h07: c = C_SRAV;
                6'h18: c = C_MULT;  6'h19: c = C_MULTU; 6'h1A: c = C_DIV;
                6'h1B: c = C_DIVU;  6'h23: c = C_SUB;   6'h24: c = C_AND;
                6'h25: c = C_OR;    6'h26: c = C_XOR;   6'h27: c = C_NOR;
                6'h2A: c = C_SLT;   6'h2B: c = C_SLTU;
                default: c = C_ADD;
            endcase
        end else if (op == 2'b11) begin
            case (opc)
                6'h0A: c = C_SLT;  6'h0B: c = C_SLTU; 6'h0C: c = C_AND;
                6'h0D: c = C_OR;   6'h0E: c = C_XOR;  6'h0F: c = C_LUI;
                default: c = C_ADD;
            endcase
        end
        return c;
    endfunction

    function automatic void model(input int c, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] h,
                                  output logic [31:0] l);
        longint sa, sb, ps;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0; h = '0; l = '0;
        case (c)
            C_ADD:  r = a + b;
            C_SUB:  r = a - b;
            C_AND:  r = a & b;
            C_OR:   r = a | b;
            C_XOR:  r = a ^ b;
            C_NOR:  r = ~(a | b);
            C_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            C_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
            C_SLL:  begin pu = ub << sh;      r = pu[31:0]; end
            C_SRL:  begin pu = ub >> sh;      r = pu[31:0]; end
            C_SRA:  begin ps = sb >>> sh;     r = ps[31:0]; end
            C_SLLV: begin pu = ub << a[4:0];  r = pu[31:0]; end
            C_SRLV: begin pu = ub >> a[4:0];  r = pu[31:0]; end
            C_SRAV: begin ps = sb >>> a[4:0]; r = ps[31:0]; end
            C_LUI:  r = {b[15:0], 16'h0000};
            C_MULT:  begin ps = sa * sb; h = ps[63:32]; l = ps[31:0]; end
            C_MULTU: begin pu = ua * ub; h = pu[63:32]; l = pu[31:0]; end
            C_DIV: if (b != 0) begin
                ps = sa / sb; l = ps[31:0];
                ps = sa % sb; h = ps[31:0];
            end
            C_DIVU: if (b != 0) begin
                pu = ua / ub; l = pu[31:0];
                pu = ua % ub; h = pu[31:0];
            end
            default: r = a + b;
        endcase
    endfunction

    function automatic logic [31:0] pick_target();
        if (exec_if.jump2) return exec_if.read_data_a;
        if (exec_if.jump1) return exec_if.jump_addr;
        if (exec_if.condition_met) return exec_if.branch_addr;
        return exec_if.pc_plus4;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic cm, input logic j1, input logic j2);
        exec_if.alu_op        = op;
        exec_if.opcode        = opc;
        exec_if.function_code = fn;
        exec_if.shamt         = sh;
        exec_if.A             = a;
        exec_if.B             = b;
        exec_if.condition_met = cm;
        exec_if.jump1         = j1;
        exec_if.jump2         = j2;
        exec_if.branch_addr   = $urandom;
        exec_if.jump_addr     = $urandom;
        exec_if.read_data_a   = $urandom;
        exec_if.pc_plus4      = $urandom;
    endtask

    task automatic check_comb(input string tag);
        int c;
        logic [31:0] r, h, l;
        c = decode(exec_if.alu_op, exec_if.opcode, exec_if.function_code);
        model(c, exec_if.shamt, exec_if.A, exec_if.B, r, h, l);
        check({tag, ".ctrl"}, 64'(exec_if.alu_ctrl_in), 64'(c[4:0]));
        check({tag, ".out"},  64'(exec_if.alu_out), 64'(r));
        check({tag, ".zero"}, 64'(exec_if.zero), 64'(r == 32'b0));
        check({tag, ".hi"},   64'(exec_if.hi), 64'(h));
        check({tag, ".lo"},   64'(exec_if.lo), 64'(l));
        check({tag, ".tgt0"}, 64'(exec_if.tgt_addr_0), 64'(pick_target()));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [5:0] functs [22];
        functs = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h11, 6'h13, 6'h18,
                   6'h19, 6'h1A, 6'h1B, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        n_checks = 0;
        n_pass   = 0;

        reset = 1'b1;
        exec_if.clk_enable = 1'b0;
        drive(2'b00, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        exec_if.branch_addr = '0;
        exec_if.jump_addr   = '0;
        exec_if.read_data_a = '0;
        exec_if.pc_plus4    = '0;
        #1;
        check("rst.tgt1", 64'(exec_if.tgt_addr_1), 64'h0);
        check("rst.ctrl", 64'(exec_if.alu_ctrl_in), 64'(C_ADD));
        check("rst.out",  64'(exec_if.alu_out), 64'h0);
        check("rst.zero", 64'(exec_if.zero), 64'h1);
        check("rst.hilo", {exec_if.hi, exec_if.lo}, 64'h0);
        check("rst.tgt0", 64'(exec_if.tgt_addr_0), 64'h0);

        // Directed boundary cases
        drive(2'b10, 6'h00, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0); #1;
        check("slt.out", 64'(exec_if.alu_out), 64'h1);
        check_comb("slt");
        drive(2'b10, 6'h00, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0); #1;
        check("sltu.out", 64'(exec_if.alu_out), 64'h0);
        check_comb("sltu");
        drive(2'b11, 6'h0F, 6'h00, 5'd0, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 1'b0); #1;
        check("lui.out",  64'(exec_if.alu_out), 64'h1234_0000);
        check("lui.zero", 64'(exec_if.zero), 64'h0);
        drive(2'b10, 6'h00, 6'h18, 5'd0, 32'hFFFF_FFFE, 32'h3, 1'b0, 1'b0, 1'b0); #1;
        check("mult.hilo", {exec_if.hi, exec_if.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        check("mult.out",  64'(exec_if.alu_out), 64'h0);
        drive(2'b10, 6'h00, 6'h1B, 5'd0, 32'h7, 32'h0, 1'b0, 1'b0, 1'b0); #1;
        check("divu0.hilo", {exec_if.hi, exec_if.lo}, 64'h0);
        drive(2'b10, 6'h00, 6'h1A, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0); #1;
        check("divovf.hilo", {exec_if.hi, exec_if.lo}, 64'h0000_0000_8000_0000);
        drive(2'b10, 6'h00, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, 1'b0); #1;
        check("divneg.hilo", {exec_if.hi, exec_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        drive(2'b10, 6'h00, 6'h03, 5'd4, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0); #1;
        check("sra.out", 64'(exec_if.alu_out), 64'hF800_0000);
        drive(2'b10, 6'h00, 6'h06, 5'd0, 32'h24, 32'h8000_0000, 1'b0, 1'b0, 1'b0); #1;
        check("srlv.out", 64'(exec_if.alu_out), 64'h0800_0000);
        drive(2'b00, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1); #1;
        check("tgt.jr", 64'(exec_if.tgt_addr_0), 64'(exec_if.read_data_a));
        drive(2'b00, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0); #1;
        check("tgt.j", 64'(exec_if.tgt_addr_0), 64'(exec_if.jump_addr));
        drive(2'b00, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); #1;
        check("tgt.br", 64'(exec_if.tgt_addr_0), 64'(exec_if.branch_addr));
        drive(2'b00, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); #1;
        check("tgt.pc4", 64'(exec_if.tgt_addr_0), 64'(exec_if.pc_plus4));
        check("rsthold.tgt1", 64'(exec_if.tgt_addr_1), 64'h0);

        // Random combinational sweep
        for (int i = 0; i < 400; i++) begin
            logic [5:0] fn, opc;
            fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 21)];
            opc = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(8, 15));
            drive(2'($urandom), opc, fn, 5'($urandom), rand_operand(), rand_operand(),
                  1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check_comb("rand");
        end

        // Target register: release reset away from the clock edge
        @(negedge clk);
        reset = 1'b0;
        exp_tgt1 = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            drive(2'($urandom), 6'($urandom), 6'($urandom), 5'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom));
            exec_if.clk_enable = 1'($urandom);
            #1;
            if (exec_if.clk_enable) exp_tgt1 = pick_target();
            @(posedge clk);
            #1;
            check("reg.tgt1", 64'(exec_if.tgt_addr_1), 64'(exp_tgt1));
        end

        @(negedge clk);
        drive(2'b00, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        exec_if.jump_addr  = 32'hBFC0_0010;
        exec_if.clk_enable = 1'b1;
        @(posedge clk);
        #1;
        exec_if.clk_enable = 1'b0;
        check("load.tgt1", 64'(exec_if.tgt_addr_1), 64'hBFC0_0010);
        #1;
        reset = 1'b1;
        #1;
        check("asyncrst.tgt1", 64'(exec_if.tgt_addr_1), 64'h0);
        exec_if.clk_enable = 1'b1;
        @(posedge clk);
        #1;
        check("rstprio.tgt1", 64'(exec_if.tgt_addr_1), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        exec_if.clk_enable = 1'b0;
        @(posedge clk);
        #1;
        check("hold.tgt1", 64'(exec_if.tgt_addr_1), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_exec_unit.md
# mips_exec_unit

Combinational execute-stage datapath for the multicycle MIPS CPU.
- Decodes the ALU operation from the control's `alu_op` and the instruction fields.
- Performs the 32-bit ALU / multiply / divide operation.
- Selects the next-PC target (PC+4, branch, jump, or register jump).
- Registers that target for use after the delay slot.

It sits between the register file / immediate mux and the PC mux, memory address mux and HI/LO registers.

## Interface
No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears the target register
- `clk_enable`  in  1  target register load enable (high during EXEC)
- `alu_op`  in  2  00 add, 01 subtract (branch compare), 10 R-type (use funct), 11 I-type (use opcode)
- `opcode`  in  6  instruction[31:26]
- `function_code`  in  6  instruction[5:0]
- `shamt`  in  5  instruction[10:6]
- `A`  in  32  rs data
- `B`  in  32  rt data or extended immediate
- `branch_addr`, `jump_addr`, `read_data_a`, `pc_plus4`  in  32 each  candidate targets
- `condition_met`, `jump1`, `jump2`  in  1 each  branch taken, J/JAL, JR/JALR
- `alu_ctrl_in`  out  5  decoded ALU operation
- `alu_out`  out  32  result
- `zero`  out  1  `alu_out == 0`
- `hi`, `lo`  out  32 each  multiply/divide results
- `tgt_addr_0`  out  32  combinational selected target
- `tgt_addr_1`  out  32  registered target

## Operation
ALU control decode:
- `alu_op` 00 → ADD; 01 → SUB.
- `alu_op` 10, by funct:
  - 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV
  - 18 MULT, 19 MULTU, 1A DIV, 1B DIVU
  - 21 ADD, 23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU
  - 08/09 (JR/JALR) and 11/13 (MTHI/MTLO) → ADD.
  - Any other funct → ADD.
- `alu_op` 11, by opcode:
  - 09 ADD, 0A SLT, 0B SLTU, 0C AND, 0D OR, 0E XOR, 0F LUI
  - Any other opcode → ADD.

ALU, all operations mod 2^32 with no overflow trap:
- ADD → A+B; SUB → A−B; AND, OR, XOR, NOR are bitwise.
- SLT: signed compare → 1 or 0. SLTU: unsigned compare → 1 or 0.
- SLL, SRL, SRA: B shifted by `shamt`.
- SLLV, SRLV, SRAV: B shifted by A[4:0].
- LUI → {B[15:0], 16'h0}.
- MULT / MULTU: 64-bit signed / unsigned product; `hi` = upper word, `lo` = lower word; `alu_out` = 0.
- DIV / DIVU: `lo` = quotient and `hi` = remainder, truncating toward zero; remainder takes the sign of the dividend.
  - Divisor 0: `hi` = `lo` = 0.
  - Signed 0x80000000 / −1: `lo` = 0x80000000, `hi` = 0.
- Non-mult/div operations drive `hi` = `lo` = 0.

Target select, in priority order:
1. `jump2` → `read_data_a`
2. else `jump1` → `jump_addr`
3. else `condition_met` → `branch_addr`
4. else `pc_plus4`

## Timing
- All outputs except `tgt_addr_1` are combinational, with zero-cycle latency from inputs.
- `tgt_addr_1` loads `tgt_addr_0` on a rising `clk` when `clk_enable` = 1; otherwise it holds.
- `reset` asserted forces `tgt_addr_1` = 0 immediately, independent of `clk`. It has priority over `clk_enable` and stays 0 while asserted.
- Reset values of other outputs follow their inputs. With all-zero inputs: `alu_ctrl_in` = ADD, `alu_out` = 0, `zero` = 1, `hi` = `lo` = 0, `tgt_addr_0` = 0.

## Structure
- Package `mips_exec_pkg` holds the 5-bit `alu_ctrl_t` enum:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7
  - SLL=8, SRL=9, SRA=10, SLLV=11, SRLV=12, SRAV=13, LUI=14
  - MULT=15, MULTU=16, DIV=17, DIVU=18
- The package also holds the opcode and funct localparams.
- One natural sub-module, `exec_alu_core`, contains the arithmetic. Decode, target select and the target register stay in the top.

## Test plan
- `alu_op`=10, funct=2A, A=0xFFFFFFFF, B=1 → SLT, `alu_out`=1. Same inputs with funct=2B → `alu_out`=0.
- `alu_op`=11, opcode=0F, B=0x00001234 → `alu_out`=0x12340000, `zero`=0.
- MULT with A=0xFFFFFFFE (−2), B=3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. DIVU with A=7, B=0 → `hi`=`lo`=0.
- SRA with `shamt`=4, B=0x80000000 → 0xF8000000. SRLV with A=0x24, B=0x80000000 → 0x08000000 (A[4:0]=4).
- `jump1`=1, `jump2`=1, `condition_met`=1 → `tgt_addr_0`=`read_data_a`. All three low → `pc_plus4`.
- Pulse `clk_enable` with `tgt_addr_0`=0xBFC00010 → `tgt_addr_1` becomes 0xBFC00010 after the edge. Assert `reset` mid-cycle → `tgt_addr_1`=0 before the next edge.
